// File: rtl/spdif_frame_ctrl.sv
// S/PDIF subframe assembler: collects 28 decoded time-slot bits per preamble, tracks lock and timeout.
// Optional parity check is built when SPDIF_PARITY_CHECK_EN is defined.
module spdif_frame_ctrl #(
    parameter int TIMEOUT  = 256,
    parameter int LOCK_CNT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_head,
    input  logic        i_shift_ena,
    input  logic        i_zero,
    input  logic        i_one,
    output logic [23:0] o_sample,
    output logic        o_v,
    output logic        o_u,
    output logic        o_c,
    output logic        o_chan,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_locked
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT_HEAD} state_t;

    state_t      r_state, w_state_nxt;
    logic [26:0] r_shift;
    logic [4:0]  r_cnt;
    logic [15:0] r_tmo;
    logic [3:0]  r_good;
    logic [23:0] r_sample;
    logic        r_v, r_u, r_c, r_chan, r_valid, r_err, r_locked;

    logic w_act, w_tmo_fire, w_bit_ok, w_par_err;
    logic w_shift, w_clr, w_good, w_bad;

    assign w_act      = i_head | i_shift_ena;
    assign w_tmo_fire = !w_act && (r_tmo == 16'(TIMEOUT - 1));
    assign w_bit_ok   = i_zero ^ i_one;

`ifdef SPDIF_PARITY_CHECK_EN
    // Slots 4..31 carry even parity, so the XOR of all 28 received bits must be 0.
    assign w_par_err = ^{i_one, r_shift};
`else
    assign w_par_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_clr       = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (w_tmo_fire) begin
            w_state_nxt = S_IDLE;
            w_bad       = r_locked;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_head) begin
                        w_state_nxt = S_RECV;
                        w_clr       = 1'b1;
                    end
                end
                S_RECV: begin
                    // A preamble always wins over a coincident bit strobe.
                    if (i_head) begin
                        w_bad = 1'b1;
                        w_clr = 1'b1;
                    end else if (i_shift_ena) begin
                        if (!w_bit_ok) begin
                            w_bad       = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_shift = 1'b1;
                            if (r_cnt == 5'd27) begin
                                w_state_nxt = S_WAIT_HEAD;
                                w_bad       = w_par_err;
                                w_good      = !w_par_err;
                            end
                        end
                    end
                end
                S_WAIT_HEAD: begin
                    if (i_head) begin
                        w_state_nxt = S_RECV;
                        w_clr       = 1'b1;
                    end else if (i_shift_ena) begin
                        w_bad       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_good   <= '0;
            r_sample <= '0;
            r_v      <= 1'b0;
            r_u      <= 1'b0;
            r_c      <= 1'b0;
            r_chan   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_good;
            r_err   <= w_bad;

            if (w_act)
                r_tmo <= '0;
            else if (r_tmo != 16'(TIMEOUT))
                r_tmo <= r_tmo + 16'd1;

            if (w_clr)
                r_cnt <= '0;
            else if (w_shift)
                r_cnt <= r_cnt + 5'd1;

            // LSB-first: after 27 shifts slot 4 sits at bit 0; the 28th bit is taken live.
            if (w_shift)
                r_shift <= {i_one, r_shift[26:1]};

            if (w_good) begin
                r_sample <= r_shift[23:0];
                r_v      <= r_shift[24];
                r_u      <= r_shift[25];
                r_c      <= r_shift[26];
            end

            if (w_bad || w_tmo_fire) begin
                r_good   <= '0;
                r_locked <= 1'b0;
            end else if (w_good) begin
                if (r_good != 4'(LOCK_CNT))
                    r_good <= r_good + 4'd1;
                if (r_good >= 4'(LOCK_CNT - 1))
                    r_locked <= 1'b1;
            end

            // Channel index alternates only across subframes delivered while in lock.
            if (!r_locked)
                r_chan <= 1'b0;
            else if (r_valid)
                r_chan <= ~r_chan;
        end
    end

    assign o_sample = r_sample;
    assign o_v      = r_v;
    assign o_u      = r_u;
    assign o_c      = r_c;
    assign o_chan   = r_chan;
    assign o_valid  = r_valid;
    assign o_err    = r_err;
    assign o_locked = r_locked;

endmodule

// File: tb/tb_spdif_frame_ctrl.sv
// Directed bench for spdif_frame_ctrl: table of complete subframes plus hand-built corner sequences.
module tb_spdif_frame_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_head = 1'b0;
    logic        i_shift_ena = 1'b0;
    logic        i_zero = 1'b0;
    logic        i_one = 1'b0;
    logic [23:0] o_sample;
    logic        o_v, o_u, o_c, o_chan, o_valid, o_err, o_locked;

    int n_vec = 0;
    int n_bad = 0;

    spdif_frame_ctrl #(.TIMEOUT(256), .LOCK_CNT(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_head(i_head), .i_shift_ena(i_shift_ena),
        .i_zero(i_zero), .i_one(i_one), .o_sample(o_sample), .o_v(o_v), .o_u(o_u),
        .o_c(o_c), .o_chan(o_chan), .o_valid(o_valid), .o_err(o_err), .o_locked(o_locked)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [23:0] smp;
        logic        v, u, c, odd;
        logic        exp_valid, exp_err, exp_locked, exp_chan;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic h, input logic s, input logic z, input logic o);
        i_head = h; i_shift_ena = s; i_zero = z; i_one = o;
        @(posedge i_clk);
        #1;
        i_head = 1'b0; i_shift_ena = 1'b0; i_zero = 1'b0; i_one = 1'b0;
    endtask

    function automatic logic [27:0] mkword(input logic [23:0] s, input logic v, input logic u,
                                           input logic c, input logic odd);
        logic p;
        p = (^{c, u, v, s}) ^ odd;
        return {p, c, u, v, s};
    endfunction

    task automatic send_bits(input logic [27:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++)
            step(1'b0, 1'b1, ~w[i], w[i]);
    endtask

    // Preamble then 28 bits; on return outputs reflect the edge that took the 28th bit.
    task automatic send_frame(input logic [27:0] w);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(w, 0, 28);
    endtask

    initial begin
        logic [27:0] w;
        logic [23:0] held;
        logic        seen;
        int          k;

        tbl[0] = '{24'hA5F00F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{24'h123456, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef SPDIF_PARITY_CHECK_EN
        tbl[4] = '{24'h0F0F0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        tbl[4] = '{24'h0F0F0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

        // Outputs while held in reset
        #12;
        chk("rst_sample", 32'(o_sample), 32'h0);
        chk("rst_vuc", 32'({o_v, o_u, o_c}), 32'h0);
        chk("rst_flags", 32'({o_chan, o_valid, o_err, o_locked}), 32'h0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            w = mkword(tbl[i].smp, tbl[i].v, tbl[i].u, tbl[i].c, tbl[i].odd);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            send_bits(w, 0, 27);
            chk($sformatf("t%0d_pre_valid", i), 32'({o_valid, o_err}), 32'h0);
            send_bits(w, 27, 1);
            chk($sformatf("t%0d_valid", i), 32'(o_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("t%0d_err", i), 32'(o_err), 32'(tbl[i].exp_err));
            chk($sformatf("t%0d_locked", i), 32'(o_locked), 32'(tbl[i].exp_locked));
            if (tbl[i].exp_valid) begin
                chk($sformatf("t%0d_chan", i), 32'(o_chan), 32'(tbl[i].exp_chan));
                chk($sformatf("t%0d_sample", i), 32'(o_sample), 32'(tbl[i].smp));
                chk($sformatf("t%0d_vuc", i), 32'({o_v, o_u, o_c}),
                    32'({tbl[i].v, tbl[i].u, tbl[i].c}));
            end
            held = o_sample;
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("t%0d_pulse_end", i), 32'({o_valid, o_err}), 32'h0);
            chk($sformatf("t%0d_hold", i), 32'(o_sample), 32'(held));
        end

        // Preamble and strobe together in WAIT_HEAD: preamble wins, bit dropped
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("coinc_no_err", 32'(o_err), 32'h0);
        w = mkword(24'h3C3C3C, 1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(w, 0, 28);
        chk("coinc_valid", 32'(o_valid), 32'h1);
        chk("coinc_sample", 32'(o_sample), 32'h3C3C3C);

        // Short subframe: preamble after 10 bits
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(w, 0, 10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("short_err", 32'(o_err), 32'h1);
        chk("short_unlock", 32'(o_locked), 32'h0);
        w = mkword(24'h600DF0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(w, 0, 28);
        chk("short_recover", 32'({o_valid, o_err}), 32'h2);
        chk("short_rec_sample", 32'(o_sample), 32'h600DF0);

        // 29th strobe with no preamble
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("overlong_err", 32'({o_valid, o_err}), 32'h1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("idle_shift_ignored", 32'(o_err), 32'h0);

        // Invalid bit symbol (zero and one both set)
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(w, 0, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("badbit_err", 32'(o_err), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("badbit_idle", 32'(o_err), 32'h0);

        // Lock up, then starve the block of strobes
        send_frame(mkword(24'h111111, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(mkword(24'h222222, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("tmo_locked", 32'(o_locked), 32'h1);
        k = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge i_clk); #1;
            if (o_err) begin
                k = c;
                break;
            end
        end
        chk("tmo_cycle", 32'(k), 32'd256);
        chk("tmo_unlock", 32'(o_locked), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo_pulse_end", 32'(o_err), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("tmo_idle_shift", 32'(o_err), 32'h0);

        // Asynchronous reset in the middle of a subframe
        send_frame(mkword(24'h777777, 1'b1, 1'b1, 1'b1, 1'b0));
        send_frame(mkword(24'h888888, 1'b1, 1'b1, 1'b1, 1'b0));
        w = mkword(24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(w, 0, 15);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_sample", 32'(o_sample), 32'h0);
        chk("arst_flags", 32'({o_v, o_u, o_c, o_chan, o_valid, o_err, o_locked}), 32'h0);
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 15; i < 28; i++) begin
            step(1'b0, 1'b1, ~w[i], w[i]);
            seen = seen | o_valid | o_err;
        end
        chk("arst_no_pulse", 32'(seen), 32'h0);
        send_frame(w);
        chk("arst_recover", 32'({o_valid, o_err}), 32'h2);
        chk("arst_rec_sample", 32'(o_sample), 32'hABCDEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
